// File: rtl/param_counter_pkg.sv
// Shared constants and helpers for the parametrised LED counter.
package param_counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Bits needed to hold values 0..v-1; constant-evaluated for the prescaler width.
  function automatic int unsigned clog2(input longint unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 64; i++) begin
      if ((64'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/param_counter_tick_gen.sv
// Prescaler: emits a one-cycle Tick every DIV enabled clocks; Sync_clr restarts the period.
module tick_gen
  import param_counter_pkg::*;
#(
  parameter int unsigned DIV = 50000000
) (
  input  logic CLOCK_50,
  input  logic Reset,
  input  logic En,
  input  logic Sync_clr,
  output logic Tick
);

  localparam int unsigned PW = (clog2(DIV) < 1) ? 1 : clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  if (DIV < 1) begin : g_bad_div
    $error("tick_gen: DIV must be >= 1");
  end

  logic [PW-1:0] pcnt_q, pcnt_d;

  assign Tick = En & (pcnt_q == LAST);

  always_comb begin
    pcnt_d = pcnt_q;
    if (Sync_clr)  pcnt_d = '0;
    else if (Tick) pcnt_d = '0;
    else if (En)   pcnt_d = pcnt_q + PW'(1);
  end

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) pcnt_q <= '0;
    else       pcnt_q <= pcnt_d;
  end

endmodule

// File: rtl/param_counter.sv
// WIDTH-bit modulo-MOD up/down counter with prescaler, load/clear, wrap/saturate and Tc pulse.
// Optional capture register enabled by defining PARAM_COUNTER_SNAPSHOT_EN (adds Cap/Snap).
module param_counter
  import param_counter_pkg::*;
#(
  parameter int unsigned     WIDTH = 10,
  parameter longint unsigned MOD   = 64'd1 << WIDTH,
  parameter int unsigned     DIV   = 50000000
) (
  input  logic             CLOCK_50,
  input  logic             Reset,
  input  logic             En,
  input  logic             Up,
  input  logic             Sat,
  input  logic             Clr,
  input  logic             Load,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Q,
`ifdef PARAM_COUNTER_SNAPSHOT_EN
  input  logic             Cap,
  output logic [WIDTH-1:0] Snap,
`endif
  output logic             Tc
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("param_counter: WIDTH must be in 1..32");
  end
  if (MOD < 2 || MOD > (64'd1 << WIDTH)) begin : g_bad_mod
    $error("param_counter: MOD must be in 2..2**WIDTH");
  end

  // Largest count value held in WIDTH bits, so a full-range modulus never needs a wider compare.
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD - 64'd1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             step;
  logic [WIDTH-1:0] din_clamped;

  tick_gen #(.DIV(DIV)) u_tick (
    .CLOCK_50 (CLOCK_50),
    .Reset    (Reset),
    .En       (En),
    .Sync_clr (Clr | Load),
    .Tick     (step)
  );

  assign din_clamped = ({{(64-WIDTH){1'b0}}, Din} >= MOD) ? MAX_V : Din;

  always_comb begin
    q_d  = q_q;
    tc_d = 1'b0;
    if (Clr) begin
      q_d = '0;
    end else if (Load) begin
      q_d = din_clamped;
    end else if (step) begin
      if (Up == DIR_UP) begin
        if (q_q == MAX_V) begin
          q_d  = (Sat == MODE_SAT) ? MAX_V : '0;
          tc_d = 1'b1;
        end else begin
          q_d = q_q + WIDTH'(1);
        end
      end else begin
        if (q_q == '0) begin
          q_d  = (Sat == MODE_SAT) ? '0 : MAX_V;
          tc_d = 1'b1;
        end else begin
          q_d = q_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      q_q  <= '0;
      tc_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      tc_q <= tc_d;
    end
  end

  assign Q  = q_q;
  assign Tc = tc_q;

`ifdef PARAM_COUNTER_SNAPSHOT_EN
  logic [WIDTH-1:0] snap_q;

  // Captures the pre-update count; Clr deliberately does not touch it.
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset)    snap_q <= '0;
    else if (Cap) snap_q <= q_q;
  end

  assign Snap = snap_q;
`endif

endmodule

// File: tb/tb_param_counter.sv
// Directed table-driven bench: DUT A (WIDTH=4, MOD=10, DIV=1) and DUT B (same, DIV=4).
// Snapshot checks compile only when PARAM_COUNTER_SNAPSHOT_EN is defined.
module tb_param_counter;

  typedef struct {
    logic       clr;
    logic       load;
    logic       en;
    logic       up;
    logic       sat;
    logic [3:0] din;
    logic [3:0] q;
    logic       tc;
  } vec_t;

  logic clk;
  logic rst_a, en_a, up_a, sat_a, clr_a, load_a, tc_a;
  logic [3:0] din_a, q_a;
  logic rst_b, en_b, up_b, sat_b, clr_b, load_b, tc_b;
  logic [3:0] din_b, q_b;
`ifdef PARAM_COUNTER_SNAPSHOT_EN
  logic cap_a, cap_b;
  logic [3:0] snap_a, snap_b;
`endif

  int total = 0;
  int bad   = 0;

  vec_t tab_a[$];
  vec_t tab_b[$];

  param_counter #(.WIDTH(4), .MOD(10), .DIV(1)) dut_a (
    .CLOCK_50 (clk),
    .Reset    (rst_a),
    .En       (en_a),
    .Up       (up_a),
    .Sat      (sat_a),
    .Clr      (clr_a),
    .Load     (load_a),
    .Din      (din_a),
    .Q        (q_a),
`ifdef PARAM_COUNTER_SNAPSHOT_EN
    .Cap      (cap_a),
    .Snap     (snap_a),
`endif
    .Tc       (tc_a)
  );

  param_counter #(.WIDTH(4), .MOD(10), .DIV(4)) dut_b (
    .CLOCK_50 (clk),
    .Reset    (rst_b),
    .En       (en_b),
    .Up       (up_b),
    .Sat      (sat_b),
    .Clr      (clr_b),
    .Load     (load_b),
    .Din      (din_b),
    .Q        (q_b),
`ifdef PARAM_COUNTER_SNAPSHOT_EN
    .Cap      (cap_b),
    .Snap     (snap_b),
`endif
    .Tc       (tc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic clr, logic load, logic en, logic up, logic sat,
                              logic [3:0] din, logic [3:0] q, logic tc);
    vec_t v;
    v.clr = clr; v.load = load; v.en = en; v.up = up; v.sat = sat;
    v.din = din; v.q = q; v.tc = tc;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic apply_a(input vec_t v, input int idx);
    clr_a = v.clr; load_a = v.load; en_a = v.en; up_a = v.up; sat_a = v.sat; din_a = v.din;
    @(posedge clk);
    @(negedge clk);
    check($sformatf("A[%0d].q", idx), int'(q_a), int'(v.q));
    check($sformatf("A[%0d].tc", idx), int'(tc_a), int'(v.tc));
  endtask

  task automatic apply_b(input vec_t v, input int idx);
    clr_b = v.clr; load_b = v.load; en_b = v.en; up_b = v.up; sat_b = v.sat; din_b = v.din;
    @(posedge clk);
    @(negedge clk);
    check($sformatf("B[%0d].q", idx), int'(q_b), int'(v.q));
    check($sformatf("B[%0d].tc", idx), int'(tc_b), int'(v.tc));
  endtask

  initial begin
    // DUT A, DIV=1: count up 0..9 then wrap with Tc.
    for (int i = 1; i <= 9; i++) tab_a.push_back(mk(0, 0, 1, 1, 0, 4'd0, 4'(i), 0));
    tab_a.push_back(mk(0, 0, 1, 1, 0, 4'd0, 4'd0, 1));
    tab_a.push_back(mk(0, 0, 1, 1, 0, 4'd0, 4'd1, 0));
    // count down, wrap 0 -> 9
    tab_a.push_back(mk(0, 0, 1, 0, 0, 4'd0, 4'd0, 0));
    tab_a.push_back(mk(0, 0, 1, 0, 0, 4'd0, 4'd9, 1));
    tab_a.push_back(mk(0, 0, 1, 0, 0, 4'd0, 4'd8, 0));
    // clear, then saturate at 0 with repeated Tc
    tab_a.push_back(mk(1, 0, 1, 0, 0, 4'd0, 4'd0, 0));
    tab_a.push_back(mk(0, 0, 1, 0, 1, 4'd0, 4'd0, 1));
    tab_a.push_back(mk(0, 0, 1, 0, 1, 4'd0, 4'd0, 1));
    tab_a.push_back(mk(0, 0, 1, 1, 1, 4'd0, 4'd1, 0));
    // load clamps 12 -> 9, then saturate high
    tab_a.push_back(mk(0, 1, 1, 1, 1, 4'd12, 4'd9, 0));
    tab_a.push_back(mk(0, 0, 1, 1, 1, 4'd0, 4'd9, 1));
    tab_a.push_back(mk(0, 0, 1, 1, 1, 4'd0, 4'd9, 1));
    // load with En=0, Clr beats Load, hold with En=0
    tab_a.push_back(mk(0, 1, 0, 1, 0, 4'd3, 4'd3, 0));
    tab_a.push_back(mk(1, 1, 1, 1, 0, 4'd5, 4'd0, 0));
    tab_a.push_back(mk(0, 0, 0, 1, 0, 4'd0, 4'd0, 0));
    tab_a.push_back(mk(0, 1, 1, 1, 1, 4'd9, 4'd9, 0));
    tab_a.push_back(mk(0, 0, 1, 1, 0, 4'd0, 4'd0, 1));
    // clamp boundaries: 10 and 15 -> 9
    tab_a.push_back(mk(0, 1, 1, 1, 0, 4'd10, 4'd9, 0));
    tab_a.push_back(mk(0, 1, 1, 1, 0, 4'd15, 4'd9, 0));
    tab_a.push_back(mk(0, 0, 0, 1, 0, 4'd0, 4'd9, 0));
    tab_a.push_back(mk(0, 0, 1, 0, 0, 4'd0, 4'd8, 0));

    // DUT B, DIV=4: step on every 4th enabled clock; En dropped 2 clocks delays step by 2.
    tab_b.push_back(mk(0, 0, 1, 1, 0, 4'd0, 4'd0, 0));
    tab_b.push_back(mk(0, 0, 1, 1, 0, 4'd0, 4'd0, 0));
    tab_b.push_back(mk(0, 0, 1, 1, 0, 4'd0, 4'd0, 0));
    tab_b.push_back(mk(0, 0, 1, 1, 0, 4'd0, 4'd1, 0));
    tab_b.push_back(mk(0, 0, 1, 1, 0, 4'd0, 4'd1, 0));
    tab_b.push_back(mk(0, 0, 1, 1, 0, 4'd0, 4'd1, 0));
    tab_b.push_back(mk(0, 0, 0, 1, 0, 4'd0, 4'd1, 0));
    tab_b.push_back(mk(0, 0, 0, 1, 0, 4'd0, 4'd1, 0));
    tab_b.push_back(mk(0, 0, 1, 1, 0, 4'd0, 4'd1, 0));
    tab_b.push_back(mk(0, 0, 1, 1, 0, 4'd0, 4'd2, 0));
    // load restarts the prescaler period
    tab_b.push_back(mk(0, 1, 1, 1, 0, 4'd7, 4'd7, 0));
    tab_b.push_back(mk(0, 0, 1, 1, 0, 4'd0, 4'd7, 0));
    tab_b.push_back(mk(0, 0, 1, 1, 0, 4'd0, 4'd7, 0));

    rst_a = 1; en_a = 0; up_a = 1; sat_a = 0; clr_a = 0; load_a = 0; din_a = 0;
    rst_b = 1; en_b = 0; up_b = 1; sat_b = 0; clr_b = 0; load_b = 0; din_b = 0;
`ifdef PARAM_COUNTER_SNAPSHOT_EN
    cap_a = 0; cap_b = 0;
`endif
    repeat (2) @(negedge clk);
    rst_a = 0; rst_b = 0;
    check("reset.A.q", int'(q_a), 0);
    check("reset.A.tc", int'(tc_a), 0);
    check("reset.B.q", int'(q_b), 0);
    check("reset.B.tc", int'(tc_b), 0);

    foreach (tab_a[i]) apply_a(tab_a[i], i);

    // Async reset of A while Tc is high: clears without any clock edge.
    apply_a(mk(0, 1, 1, 1, 1, 4'd9, 4'd9, 0), 100);
    apply_a(mk(0, 0, 1, 1, 1, 4'd0, 4'd9, 1), 101);
    en_a = 0;
    #2 rst_a = 1;
    #1;
    check("async.A.q", int'(q_a), 0);
    check("async.A.tc", int'(tc_a), 0);
    @(negedge clk);
    rst_a = 0;

    foreach (tab_b[i]) apply_b(tab_b[i], i);

    // B now at Q=7 with prescaler at 2: async reset, then a full fresh period.
    en_b = 0;
    #2 rst_b = 1;
    #1;
    check("async.B.q", int'(q_b), 0);
    check("async.B.tc", int'(tc_b), 0);
    @(negedge clk);
    rst_b = 0;
    for (int i = 0; i < 3; i++) apply_b(mk(0, 0, 1, 1, 0, 4'd0, 4'd0, 0), 200 + i);
    apply_b(mk(0, 0, 1, 1, 0, 4'd0, 4'd1, 0), 203);
    en_b = 0;

`ifdef PARAM_COUNTER_SNAPSHOT_EN
    apply_a(mk(0, 1, 0, 1, 0, 4'd5, 4'd5, 0), 300);
    cap_a = 1;
    apply_a(mk(0, 0, 1, 1, 0, 4'd0, 4'd6, 0), 301);
    check("snap.cap", int'(snap_a), 5);
    cap_a = 0;
    apply_a(mk(1, 0, 1, 1, 0, 4'd0, 4'd0, 0), 302);
    check("snap.clr", int'(snap_a), 5);
    en_a = 0;
    #2 rst_a = 1;
    #1;
    check("snap.reset", int'(snap_a), 0);
    @(negedge clk);
    rst_a = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
